fp_resize_arbiter: RTL and testbench

- Shares one pipelined fixed-point resize unit (signed Q(IN_IW).(IN_QW) to Q(OUT_IW).(OUT_QW), optional saturation) between N_REQ requesters.
- Round-robin arbitration, valid/ready handshakes on every requester and on the single response port, requester-ID tagging of results, and per-requester sticky clipping status.
- Sits between shading/geometry stages and downstream fixed-point consumers in fp_core.

---
 rtl/fp_resize_arbiter.sv | 147 ++++++++++++++
 tb/tb_fp_resize_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_resize_arbiter.sv
// Round-robin shared fixed-point resize unit: N_REQ requesters feed a two-stage
// pipeline (capture, resize+output) with ID tagging and sticky per-requester clip flags.
module fp_resize_arbiter #(
    parameter int N_REQ  = 4,
    parameter int IN_IW  = 16,
    parameter int IN_QW  = 16,
    parameter int OUT_IW = 8,
    parameter int OUT_QW = 8
) (
    input  logic                                       clk,
    input  logic                                       rstn,
    input  logic [N_REQ-1:0]                           req_valid,
    output logic [N_REQ-1:0]                           req_ready,
    input  logic [N_REQ*(IN_IW+IN_QW)-1:0]             req_data,
    input  logic [N_REQ-1:0]                           req_clip,
    output logic                                       rsp_valid,
    input  logic                                       rsp_ready,
    output logic [OUT_IW+OUT_QW-1:0]                   rsp_data,
    output logic                                       rsp_clipping,
    output logic [((N_REQ > 2) ? $clog2(N_REQ) : 1)-1:0] rsp_id,
    output logic [N_REQ-1:0]                           clip_status,
    input  logic [N_REQ-1:0]                           clip_clear,
    output logic                                       busy
);
    localparam int IN_W  = IN_IW + IN_QW;
    localparam int OUT_W = OUT_IW + OUT_QW;
    localparam int ID_W  = (N_REQ > 2) ? $clog2(N_REQ) : 1;
    localparam int LSH   = (OUT_QW > IN_QW) ? (OUT_QW - IN_QW) : 0;
    localparam int RSH   = (IN_QW >= OUT_QW) ? (IN_QW - OUT_QW) : 0;
    // Wide enough to hold any shifted input plus the output range check bits.
    localparam int EXT_W = IN_W + LSH + OUT_W;
    localparam logic [ID_W:0]   N_REQ_W = (ID_W+1)'(N_REQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

    logic [ID_W-1:0] r_ptr;
    logic            r_s1_valid;
    logic [IN_W-1:0] r_s1_data;
    logic            r_s1_clip;
    logic [ID_W-1:0] r_s1_id;

    logic            w_s1_adv;
    logic            w_s2_adv;
    logic            w_found;
    logic [ID_W-1:0] w_gnt_id;
    logic [ID_W:0]   w_idx;
    logic            w_hs;
    logic [IN_W-1:0] w_sel_data;
    logic [ID_W-1:0] w_ptr_next;

    assign w_s2_adv = !rsp_valid || rsp_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign busy     = r_s1_valid | rsp_valid;

    // First valid requester at or after the pointer, wrapping modulo N_REQ.
    always_comb begin
        w_found  = 1'b0;
        w_gnt_id = '0;
        w_idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = {1'b0, r_ptr} + (ID_W+1)'(k);
            if (w_idx >= N_REQ_W) begin
                w_idx = w_idx - N_REQ_W;
            end
            if (!w_found && req_valid[w_idx[ID_W-1:0]]) begin
                w_found  = 1'b1;
                w_gnt_id = w_idx[ID_W-1:0];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
            assign req_ready[gi] = rstn & w_found & w_s1_adv & (w_gnt_id == ID_W'(gi));
        end
    endgenerate

    assign w_hs       = |(req_valid & req_ready);
    assign w_sel_data = req_data[w_gnt_id*IN_W +: IN_W];
    assign w_ptr_next = (w_gnt_id == LAST_ID) ? '0 : w_gnt_id + 1'b1;

    logic signed [EXT_W-1:0]   w_ext;
    logic signed [EXT_W-1:0]   w_shifted;
    logic        [EXT_W-OUT_W:0] w_hi;
    logic                      w_oor;
    logic        [OUT_W-1:0]   w_sat;
    logic        [OUT_W-1:0]   w_res;

    assign w_ext = {{(EXT_W-IN_W){r_s1_data[IN_W-1]}}, r_s1_data};

    generate
        if (IN_QW >= OUT_QW) begin : g_rsh
            assign w_shifted = w_ext >>> RSH;
        end else begin : g_lsh
            assign w_shifted = w_ext <<< LSH;
        end
    endgenerate

    // In range only if every bit from the output sign bit upward agrees.
    assign w_hi  = w_shifted[EXT_W-1:OUT_W-1];
    assign w_oor = !((&w_hi) || !(|w_hi));
    assign w_sat = w_shifted[EXT_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    assign w_res = (w_oor && r_s1_clip) ? w_sat : w_shifted[OUT_W-1:0];

    logic [N_REQ-1:0] w_clip_set;
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_clip_set
            assign w_clip_set[gi] = rsp_valid & rsp_ready & rsp_clipping & (rsp_id == ID_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_ptr        <= '0;
            r_s1_valid   <= 1'b0;
            r_s1_data    <= '0;
            r_s1_clip    <= 1'b0;
            r_s1_id      <= '0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_clipping <= 1'b0;
            rsp_id       <= '0;
            clip_status  <= '0;
        end else begin
            if (w_hs) begin
                r_ptr <= w_ptr_next;
            end
            if (w_s1_adv) begin
                r_s1_valid <= w_hs;
                if (w_hs) begin
                    r_s1_data <= w_sel_data;
                    r_s1_clip <= req_clip[w_gnt_id];
                    r_s1_id   <= w_gnt_id;
                end
            end
            if (w_s2_adv) begin
                rsp_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    rsp_data     <= w_res;
                    rsp_clipping <= w_oor;
                    rsp_id       <= r_s1_id;
                end
            end
            // Set takes priority over a simultaneous clear.
            clip_status <= (clip_status & ~clip_clear) | w_clip_set;
        end
    end
endmodule

// File: tb/tb_fp_resize_arbiter.sv
// Scoreboard bench for fp_resize_arbiter: handshake observer queues hand-computed
// expectations, a response monitor pops and compares them.
module tb_fp_resize_arbiter;
    localparam int N = 4;

    typedef struct packed {
        logic [15:0] d;
        logic        c;
        logic [1:0]  id;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N*32-1:0] req_data;
    logic [N-1:0]  req_clip;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [15:0]   rsp_data;
    logic          rsp_clipping;
    logic [1:0]    rsp_id;
    logic [N-1:0]  clip_status;
    logic [N-1:0]  clip_clear;
    logic          busy;

    logic [31:0] cur_data [N];
    logic        cur_clip [N];
    logic [15:0] cur_ed   [N];
    logic        cur_ec   [N];

    exp_t sb_q[$];
    int   gnt_log[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   hs_count = 0;

    always #5 clk = ~clk;

    fp_resize_arbiter #(.N_REQ(4), .IN_IW(16), .IN_QW(16), .OUT_IW(8), .OUT_QW(8)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_clip(req_clip),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_clipping(rsp_clipping), .rsp_id(rsp_id),
        .clip_status(clip_status), .clip_clear(clip_clear), .busy(busy)
    );

    always_comb begin
        req_data = '0;
        req_clip = '0;
        for (int i = 0; i < N; i++) begin
            req_data[i*32 +: 32] = cur_data[i];
            req_clip[i]          = cur_clip[i];
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Request-side observer: records every accepted request and its expected result.
    always @(negedge clk) begin
        if (rstn) begin
            chk("ready_onehot0", 32'($countones(req_ready) <= 1), 32'd1);
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb_q.push_back('{d: cur_ed[i], c: cur_ec[i], id: 2'(i)});
                    gnt_log.push_back(i);
                    hs_count++;
                    $display("REQ  id=%0d data=0x%08h clip=%0b", i, cur_data[i], cur_clip[i]);
                end
            end
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        if (rstn && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_rsp", {14'd0, rsp_id, rsp_data}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                $display("RSP  id=%0d data=0x%04h clipping=%0b (exp id=%0d data=0x%04h clipping=%0b)",
                         rsp_id, rsp_data, rsp_clipping, e.id, e.d, e.c);
                chk("rsp_data", 32'(rsp_data), 32'(e.d));
                chk("rsp_clipping", 32'(rsp_clipping), 32'(e.c));
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(int r, logic [31:0] d, logic c, logic [15:0] ed, logic ec);
        cur_data[r] = d;
        cur_clip[r] = c;
        cur_ed[r]   = ed;
        cur_ec[r]   = ec;
    endtask

    task automatic issue(int r, logic [31:0] d, logic c, logic [15:0] ed, logic ec);
        bit got;
        set_vec(r, d, c, ed, ec);
        req_valid[r] = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (req_ready[r]) got = 1'b1;
        end
        if (!got) chk("issue_timeout", 32'd0, 32'd1);
        tick();
        req_valid[r] = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 50 && sb_q.size() != 0; t++) @(negedge clk);
        chk("drain_empty", 32'(sb_q.size()), 32'd0);
        tick();
    endtask

    initial begin
        int acc;
        logic [15:0] held;
        bit seen;
        rstn = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b1;
        clip_clear = '0;
        for (int i = 0; i < N; i++) set_vec(i, 32'd0, 1'b0, 16'd0, 1'b0);

        // Reset state
        repeat (2) tick();
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_clip_status", 32'(clip_status), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        tick();
        req_valid = '0;
        rstn = 1'b1;
        tick();

        // Single request and latency
        issue(0, 32'h0001_8000, 1'b1, 16'h0180, 1'b0);
        @(negedge clk);
        chk("lat_cycle1_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("lat_cycle2_rsp_valid", 32'(rsp_valid), 32'd1);
        drain();

        // Saturation, wrap, floor and range boundaries
        issue(0, 32'h0100_0000, 1'b1, 16'h7FFF, 1'b1);
        issue(0, 32'h0100_0000, 1'b0, 16'h0000, 1'b1);
        issue(0, 32'hFE00_0000, 1'b1, 16'h8000, 1'b1);
        issue(0, 32'hFFFF_FF80, 1'b1, 16'hFFFF, 1'b0);
        issue(0, 32'hFF80_0000, 1'b1, 16'h8000, 1'b0);
        issue(0, 32'h0080_0000, 1'b1, 16'h7FFF, 1'b1);
        issue(0, 32'h0080_0000, 1'b0, 16'h8000, 1'b1);
        issue(3, 32'h007F_FFFF, 1'b1, 16'h7FFF, 1'b0);
        drain();
        @(negedge clk);
        chk("sat_clip_status", 32'(clip_status), 32'h1);
        tick();
        clip_clear = '1;
        tick();
        clip_clear = '0;
        @(negedge clk);
        chk("clear_all_status", 32'(clip_status), 32'h0);
        tick();

        // Round-robin fairness with all requesters valid
        for (int i = 0; i < N; i++) set_vec(i, 32'((i+1) << 16), 1'b0, 16'((i+1) << 8), 1'b0);
        gnt_log.delete();
        acc = hs_count;
        req_valid = '1;
        repeat (8) tick();
        req_valid = '0;
        chk("rr_handshakes", 32'(hs_count - acc), 32'd8);
        for (int j = 0; j < 8; j++) begin
            chk("rr_grant_order", (j < gnt_log.size()) ? 32'(gnt_log[j]) : 32'hDEAD, 32'(j % 4));
        end
        drain();

        // Backpressure on requester 2
        rsp_ready = 1'b0;
        set_vec(2, 32'h0002_0000, 1'b0, 16'h0200, 1'b0);
        req_valid[2] = 1'b1;
        acc = 0;
        held = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 2) begin
                held = rsp_data;
                chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
                chk("bp_first_data", 32'(rsp_data), 32'h0200);
            end
            if (c == 3) chk("bp_rsp_stable", 32'(rsp_data), 32'(held));
            if (c >= 2) chk("bp_ready_low", 32'(req_ready), 32'd0);
            if (req_ready[2]) acc++;
            tick();
            if (acc == 1) set_vec(2, 32'h0003_0000, 1'b0, 16'h0300, 1'b0);
            if (acc == 2) set_vec(2, 32'h0004_0000, 1'b0, 16'h0400, 1'b0);
        end
        chk("bp_accepted", 32'(acc), 32'd2);
        req_valid[2] = 1'b0;
        rsp_ready = 1'b1;
        drain();

        // Sticky clip flags with set/clear collision
        issue(1, 32'h0100_0000, 1'b1, 16'h7FFF, 1'b1);
        drain();
        @(negedge clk);
        chk("sticky_set", 32'(clip_status), 32'h2);
        tick();
        rsp_ready = 1'b0;
        issue(1, 32'h0100_0000, 1'b1, 16'h7FFF, 1'b1);
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("sticky_rsp_wait", 32'(seen), 32'd1);
        tick();
        rsp_ready = 1'b1;
        clip_clear = 4'b0010;
        tick();
        clip_clear = '0;
        @(negedge clk);
        chk("sticky_set_wins", 32'(clip_status), 32'h2);
        tick();
        clip_clear = 4'b0010;
        tick();
        clip_clear = '0;
        @(negedge clk);
        chk("sticky_cleared", 32'(clip_status), 32'h0);
        tick();

        // Reset mid-operation
        issue(3, 32'hFE00_0000, 1'b1, 16'h8000, 1'b1);
        drain();
        @(negedge clk);
        chk("pre_rst_status", 32'(clip_status), 32'h8);
        tick();
        rsp_ready = 1'b0;
        set_vec(2, 32'h0005_0000, 1'b0, 16'h0500, 1'b0);
        req_valid[2] = 1'b1;
        repeat (2) tick();
        req_valid[2] = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        chk("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
        tick();
        rstn = 1'b0;
        req_valid = '1;
        @(negedge clk);
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        tick();
        sb_q.delete();
        gnt_log.delete();
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_clip_status", 32'(clip_status), 32'd0);
        chk("post_rst_first_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        rsp_ready = 1'b1;
        drain();
        chk("post_rst_grant_log", (gnt_log.size() == 1) ? 32'(gnt_log[0]) : 32'hDEAD, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end
endmodule
